// File: rtl/controle_acumulador.sv
// Sequencer that clears the accumulator, then feeds it N memory words via Load/Transfer strobes.
// Every output is a flop, so the accumulator's edge-sensitive strobes stay glitch-free.
module controle_acumulador #(
  parameter int TAMANHO     = 16,
  parameter int LARGURA_END = 4
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Iniciar,
  input  logic [LARGURA_END-1:0] EndInicial,
  input  logic [LARGURA_END:0]   N,
  input  logic [TAMANHO-1:0]     Dado,
  output logic [LARGURA_END-1:0] Endereco,
  output logic                   LerMem,
  output logic [TAMANHO-1:0]     M,
  output logic                   Load,
  output logic                   Transfer,
  output logic                   Clear,
  output logic                   Ocupado,
  output logic                   Pronto
);

  typedef enum logic [2:0] {
    OCIOSO, LIMPA, LE, ESPERA, CARREGA, TRANSFERE, FIM
  } estado_t;

  localparam logic [LARGURA_END-1:0] END_UM   = 1;
  localparam logic [LARGURA_END:0]   CONTA_UM = 1;

  estado_t                state_reg;
  logic [LARGURA_END:0]   conta_reg;

  // Outputs are assigned from the state being entered, so they are valid for that whole cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg <= OCIOSO;
      conta_reg <= '0;
      Endereco  <= '0;
      M         <= '0;
      LerMem    <= 1'b0;
      Load      <= 1'b0;
      Transfer  <= 1'b0;
      Pronto    <= 1'b0;
      Ocupado   <= 1'b0;
      Clear     <= 1'b0;
    end else begin
      LerMem   <= 1'b0;
      Load     <= 1'b0;
      Transfer <= 1'b0;
      Pronto   <= 1'b0;
      Clear    <= 1'b1;
      Ocupado  <= 1'b1;
      case (state_reg)
        OCIOSO: begin
          if (Iniciar) begin
            Endereco  <= EndInicial;
            conta_reg <= N;
            Clear     <= 1'b0;
            state_reg <= LIMPA;
          end else begin
            Ocupado <= 1'b0;
          end
        end
        LIMPA: begin
          if (conta_reg == '0) begin
            Pronto    <= 1'b1;
            state_reg <= FIM;
          end else begin
            LerMem    <= 1'b1;
            state_reg <= LE;
          end
        end
        LE: state_reg <= ESPERA;
        ESPERA: begin
          M         <= Dado;
          Load      <= 1'b1;
          state_reg <= CARREGA;
        end
        CARREGA: begin
          Transfer  <= 1'b1;
          state_reg <= TRANSFERE;
        end
        TRANSFERE: begin
          Endereco  <= Endereco + END_UM;
          conta_reg <= conta_reg - CONTA_UM;
          if (conta_reg == CONTA_UM) begin
            Pronto    <= 1'b1;
            state_reg <= FIM;
          end else begin
            LerMem    <= 1'b1;
            state_reg <= LE;
          end
        end
        FIM: begin
          Ocupado   <= 1'b0;
          state_reg <= OCIOSO;
        end
        default: begin
          Ocupado   <= 1'b0;
          state_reg <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controle_acumulador.sv
// Directed bench for controle_acumulador: memory and accumulator models plus an event scoreboard.
module tb_controle_acumulador;

  localparam int TAMANHO     = 16;
  localparam int LARGURA_END = 4;
  localparam int K_RD = 0, K_LD = 1, K_TR = 2, K_CL = 3, K_PR = 4;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] val;
  } ev_t;

  logic                   clk = 1'b0;
  logic                   Reset;
  logic                   Iniciar;
  logic [LARGURA_END-1:0] EndInicial;
  logic [LARGURA_END:0]   N;
  logic [TAMANHO-1:0]     dado_q = 16'hxxxx;
  logic [LARGURA_END-1:0] Endereco;
  logic                   LerMem;
  logic [TAMANHO-1:0]     M;
  logic                   Load;
  logic                   Transfer;
  logic                   Clear;
  logic                   Ocupado;
  logic                   Pronto;

  logic [TAMANHO-1:0] mem [16];
  logic [TAMANHO-1:0] acc_b = '0;
  logic [TAMANHO-1:0] acc_model = '0;
  logic               rst_q = 1'b1;
  bit                 mon_en = 1'b0;
  int                 cyc = 0;
  int                 checks = 0;
  int                 failures = 0;
  ev_t                evq[$];

  always #5 clk = ~clk;

  controle_acumulador #(.TAMANHO(TAMANHO), .LARGURA_END(LARGURA_END)) dut (
    .Clock(clk), .Reset(Reset), .Iniciar(Iniciar), .EndInicial(EndInicial), .N(N),
    .Dado(dado_q), .Endereco(Endereco), .LerMem(LerMem), .M(M), .Load(Load),
    .Transfer(Transfer), .Clear(Clear), .Ocupado(Ocupado), .Pronto(Pronto)
  );

  // Synchronous-read memory and a clocked accumulator (Load captures M, Transfer adds, Clear low zeroes).
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= Reset;
    if (LerMem) dado_q <= mem[Endereco];
    if (Load) acc_b <= M;
    if (!Clear) acc_model <= '0;
    else if (Transfer) acc_model <= acc_model + acc_b;
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(int kind, int c, logic [31:0] v);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = v;
    evq.push_back(e);
  endtask

  // Expected events of one command accepted at edge e; events after relative cycle 'limit' are dropped.
  task automatic plan(int e, logic [3:0] a0, int n, int limit);
    logic [15:0] s;
    logic [3:0]  a;
    s = '0;
    if (limit >= 0) push(K_CL, e, 0);
    for (int i = 0; i < n; i++) begin
      a = a0 + 4'(i);
      if (1 + 4*i <= limit) push(K_RD, e + 1 + 4*i, 32'(a));
      if (3 + 4*i <= limit) push(K_LD, e + 3 + 4*i, 32'(mem[a]));
      if (4 + 4*i <= limit) push(K_TR, e + 4 + 4*i, 0);
      s = s + mem[a];
    end
    if (1 + 4*n <= limit) push(K_PR, e + 1 + 4*n, 32'(s));
  endtask

  task automatic observe(int kind, string tag, logic [31:0] val);
    int idx;
    idx = -1;
    for (int i = 0; i < evq.size(); i++) begin
      if (evq[i].kind == kind) begin
        idx = i;
        break;
      end
    end
    check({tag, "_expected"}, (idx >= 0) ? 32'd1 : 32'd0, 32'd1);
    if (idx >= 0) begin
      check({tag, "_cycle"}, 32'(cyc), 32'(evq[idx].cyc));
      check({tag, "_value"}, val, evq[idx].val);
      evq.delete(idx);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (LerMem) observe(K_RD, "rd_addr", 32'(Endereco));
      if (Load) observe(K_LD, "load_m", 32'(M));
      if (Transfer) observe(K_TR, "transfer", 0);
      if (!Clear && !rst_q) observe(K_CL, "clear", 0);
      if (Pronto) begin
        observe(K_PR, "pronto_sum", 32'(acc_model));
        check("busy_at_fim", 32'(Ocupado), 1);
      end
      if (Load || Transfer) begin
        check("load_transfer_excl", 32'(Load & Transfer), 0);
        check("clear_with_strobe", 32'(Clear), 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(logic [3:0] a, logic [4:0] n, int limit);
    EndInicial = a;
    N          = n;
    Iniciar    = 1'b1;
    plan(cyc + 1, a, int'(n), limit);
    tick();
    Iniciar    = 1'b0;
    EndInicial = ~a;
    N          = 5'd7;
  endtask

  task automatic wait_drain(int budget);
    for (int i = 0; i < budget && evq.size() != 0; i++) tick();
    check("drain", 32'(evq.size()), 0);
    tick();
    tick();
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_lermem"}, 32'(LerMem), 0);
    check({tag, "_load"}, 32'(Load), 0);
    check({tag, "_transfer"}, 32'(Transfer), 0);
    check({tag, "_pronto"}, 32'(Pronto), 0);
    check({tag, "_ocupado"}, 32'(Ocupado), 0);
    check({tag, "_endereco"}, 32'(Endereco), 0);
    check({tag, "_m"}, 32'(M), 0);
    check({tag, "_clear"}, 32'(Clear), 0);
  endtask

  initial begin
    int e;
    Reset      = 1'b1;
    Iniciar    = 1'b0;
    EndInicial = '0;
    N          = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    repeat (3) tick();
    check_reset_outputs("reset");
    Reset = 1'b0;
    tick();
    check("clear_after_reset", 32'(Clear), 1);
    check("idle_ocupado", 32'(Ocupado), 0);
    mon_en = 1'b1;

    // Basic sum of three words
    mem[2] = 16'd5;
    mem[3] = 16'd7;
    mem[4] = 16'd9;
    start(4'd2, 5'd3, 99);
    wait_drain(40);
    check("m_holds_last", 32'(M), 9);
    check("acc_basic", 32'(acc_model), 21);
    check("idle_after_basic", 32'(Ocupado), 0);

    // Zero-length command: clear then done, no memory traffic
    start(4'd9, 5'd0, 99);
    wait_drain(20);
    check("acc_n0", 32'(acc_model), 0);

    // Address wrap from 15 to 0
    mem[15] = 16'h0100;
    mem[0]  = 16'h0023;
    start(4'd15, 5'd2, 99);
    wait_drain(40);
    check("acc_wrap", 32'(acc_model), 32'h0123);
    check("addr_after_wrap", 32'(Endereco), 1);

    // Ignored start while busy, then reset during CARREGA of word 2
    mem[5] = 16'h0011;
    mem[6] = 16'h0022;
    mem[7] = 16'h0033;
    mem[8] = 16'h0044;
    e = cyc + 1;
    start(4'd5, 5'd4, 11);
    repeat (5) tick();
    Iniciar    = 1'b1;
    EndInicial = 4'd0;
    N          = 5'd1;
    tick();
    Iniciar = 1'b0;
    repeat (5) tick();
    check("abort_cycle", 32'(cyc), 32'(e + 11));
    check("acc_partial", 32'(acc_model), 32'h0033);
    Reset = 1'b1;
    tick();
    check_reset_outputs("midop_reset");
    Reset = 1'b0;
    wait_drain(5);
    check("acc_after_reset", 32'(acc_model), 0);
    start(4'd6, 5'd2, 99);
    wait_drain(40);
    check("acc_fresh", 32'(acc_model), 32'h0055);

    // Back-to-back commands with Iniciar held high
    for (int i = 0; i < 16; i++) mem[i] = 16'd1;
    EndInicial = 4'd3;
    N          = 5'd2;
    Iniciar    = 1'b1;
    e = cyc + 1;
    plan(e, 4'd3, 2, 99);
    plan(e + 11, 4'd3, 2, 99);
    repeat (12) tick();
    Iniciar = 1'b0;
    wait_drain(40);
    check("acc_b2b", 32'(acc_model), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
